// File: rtl/lcd_sequencer.sv
// lcd_sequencer: generates the power-up, clear, home and slot-write command
// stream for a character display, with registered command words and
// NOP-filled gaps between them.
module lcd_sequencer #(
    parameter int unsigned SIZE       = 4,
    parameter logic [19:0] DELAY_INIT = 20'd750000,
    parameter logic [19:0] DELAY_CMD  = 20'd2000,
    parameter logic [19:0] DELAY_CLR  = 20'd80000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_refresh,
    input  logic        i_clear,
    output logic [10:0] o_comm,
    output logic        o_busy,
    output logic        o_init_done
);

    localparam int unsigned CNT_W  = 20;
    localparam int unsigned STEP_W = (SIZE <= 4) ? 2 : $clog2(SIZE);
    localparam logic [10:0] NOP    = 11'h200;

    typedef enum logic [2:0] {
        POWER_WAIT,
        INIT,
        CLEAR,
        HOME,
        WRITE,
        GAP,
        IDLE
    } state_e;

    state_e              state_q, state_d;
    state_e              tgt_q, tgt_d;       // where the current gap leads
    logic [STEP_W-1:0]   step_q, step_d;     // init step or slot index
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                long_q, long_d;     // current gap follows a clear
    logic                pend_ref_q, pend_ref_d;
    logic                pend_clr_q, pend_clr_d;
    logic [10:0]         comm_q, comm_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                launch;
    state_e              lstate;
    logic [STEP_W-1:0]   lstep;
    logic [CNT_W-1:0]    gap_dly;
    logic                pend_any;
    logic                direct;

    // State register; reset aborts any sequence and restarts power-up.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= POWER_WAIT;
            tgt_q      <= POWER_WAIT;
            step_q     <= '0;
            cnt_q      <= '0;
            long_q     <= 1'b0;
            pend_ref_q <= 1'b0;
            pend_clr_q <= 1'b0;
            comm_q     <= NOP;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            long_q     <= long_d;
            pend_ref_q <= pend_ref_d;
            pend_clr_q <= pend_clr_d;
            comm_q     <= comm_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state: decide when a word is launched, then what that word is.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        long_d     = long_q;
        pend_ref_d = pend_ref_q;
        pend_clr_d = pend_clr_q;
        comm_d     = NOP;
        launch     = 1'b0;
        lstate     = tgt_q;
        lstep      = step_q;
        gap_dly    = long_q ? DELAY_CLR : DELAY_CMD;
        pend_any   = pend_ref_q | pend_clr_q;
        direct     = (state_q == IDLE) && !pend_any;

        case (state_q)
            POWER_WAIT: begin
                if (cnt_q == DELAY_INIT) begin
                    launch = 1'b1;
                    lstate = INIT;
                    lstep  = '0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            GAP: begin
                if (cnt_q == gap_dly) begin
                    if (tgt_q == IDLE) begin
                        state_d = IDLE;
                    end else begin
                        launch = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            IDLE: begin
                if (pend_any) begin
                    launch     = 1'b1;
                    lstate     = pend_clr_q ? CLEAR : HOME;
                    pend_ref_d = 1'b0;
                    pend_clr_d = 1'b0;
                end else if (i_refresh || i_clear) begin
                    launch = 1'b1;
                    lstate = i_clear ? CLEAR : HOME;
                end
            end
            default: begin
                state_d = POWER_WAIT;
            end
        endcase

        // Requests while a pass is running collapse into pending flags.
        if (done_q && !direct) begin
            if (i_refresh) pend_ref_d = 1'b1;
            if (i_clear)   pend_clr_d = 1'b1;
        end

        if (launch) begin
            state_d = GAP;
            cnt_d   = '0;
            long_d  = 1'b0;
            step_d  = '0;
            case (lstate)
                INIT: begin
                    case (lstep)
                        STEP_W'(0): comm_d = 11'h038;
                        STEP_W'(1): comm_d = 11'h00C;
                        STEP_W'(2): comm_d = 11'h006;
                        default:    comm_d = 11'h001;
                    endcase
                    if (lstep == STEP_W'(3)) begin
                        tgt_d  = HOME;
                        long_d = 1'b1;
                    end else begin
                        tgt_d  = INIT;
                        step_d = lstep + STEP_W'(1);
                    end
                end
                CLEAR: begin
                    comm_d = 11'h001;
                    tgt_d  = HOME;
                    long_d = 1'b1;
                end
                HOME: begin
                    comm_d = 11'h080;
                    tgt_d  = WRITE;
                    step_d = STEP_W'(1);
                end
                WRITE: begin
                    comm_d = 11'h500 | {3'b000, 8'(lstep)};
                    tgt_d  = (lstep == STEP_W'(SIZE - 1)) ? IDLE : WRITE;
                    step_d = lstep + STEP_W'(1);
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE) || pend_ref_d || pend_clr_d;
        done_d = done_q || (state_d == IDLE);
    end

    assign o_comm      = comm_q;
    assign o_busy      = busy_q;
    assign o_init_done = done_q;

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 4: number of display byte slots (multiple of 4); slot 0 is the command path, slots 1..SIZE-1 carry data.
REQ-002 SHALL have parameter DELAY_INIT, default 20'd750000: power-up wait, in cycles.
REQ-003 SHALL have parameter DELAY_CMD, default 20'd2000: gap after each ordinary command or data write, in cycles.
REQ-004 SHALL have parameter DELAY_CLR, default 20'd80000: gap after a clear-display command, in cycles.
REQ-005 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_refresh  input  1  single-cycle request to rewrite all data slots.
REQ-008 SHALL have port i_clear  input  1  single-cycle request to issue clear-display before the next write pass.
REQ-009 SHALL have port o_comm  output  11  command word to the display stage: [10] data select, [9] RW, [8] RS, [7:0] command byte or slot index.
REQ-010 SHALL have port o_busy  output  1  high while any sequence is in progress.
REQ-011 SHALL have port o_init_done  output  1  high once the init sequence has completed; stays high until reset.

Function
REQ-012 SHALL encode NOP as 11'h200 (busy-flag read), command byte B as {3'b000,B}, and data slot j as 11'h500|j.
REQ-013 SHALL drive every o_comm value, including NOPs, from a register, with no combinational path from inputs to o_comm.
REQ-014 SHALL use states POWER_WAIT, INIT, CLEAR, HOME, WRITE, GAP and IDLE.
REQ-015 SHALL hold each non-NOP word for exactly 1 cycle, followed by exactly DELAY_CMD NOP cycles (DELAY_CLR after 0x001).
REQ-016 SHALL output NOP for exactly DELAY_INIT cycles in POWER_WAIT, counted from the first edge after reset release.
REQ-017 SHALL emit in INIT, in order: 0x038, 0x00C, 0x006, 0x001, then go to HOME.
REQ-018 SHALL have HOME emit 0x080, then go to WRITE.
REQ-019 SHALL have WRITE emit slots 1..SIZE-1 in ascending order, then go to IDLE.
REQ-020 SHALL assert o_init_done on the first IDLE cycle after the power-up pass.
REQ-021 SHALL deassert o_busy only in IDLE.
REQ-022 SHALL, on i_refresh in IDLE, present 0x080 on o_comm the next cycle; with i_clear in the same cycle, present 0x001 first (CLEAR, then HOME).
REQ-023 SHALL latch i_refresh or i_clear arriving while busy as pending flags; multiple requests collapse to one; pending work starts on the cycle after the pass would enter IDLE, with IDLE never visible (o_busy stays high).
REQ-024 SHALL clear a pending flag in the cycle its pass starts; a request arriving in that same cycle stays pending.
REQ-025 SHALL have delay counters of 20 bits; every DELAY_* value SHALL be >= 1 and < 2^20; counters SHALL not wrap.
REQ-026 SHALL ignore requests during POWER_WAIT and INIT; the power-up pass already includes a clear and a full write.

Reset
REQ-027 SHALL, while i_rst is high, hold o_comm=11'h200, o_busy=1, o_init_done=0, all counters and pending flags at 0, and state POWER_WAIT.
REQ-028 SHALL, when i_rst is asserted mid-sequence, abort the sequence immediately (asynchronously) and restart the full power-up pass after release.

Verification (SIZE=4, DELAY_INIT=10, DELAY_CMD=3, DELAY_CLR=8; cycle 0 = first edge after release)
REQ-029 SHALL cover power-up: o_comm is 0x200 on cycles 0-9, then 0x038@10, 0x00C@14, 0x006@18, 0x001@22, 0x080@31, 0x501@35, 0x502@39, 0x503@43; o_busy falls and o_init_done rises at 47.
REQ-030 SHALL cover refresh in IDLE: i_refresh at cycle N -> 0x080@N+1, 0x501@N+5, 0x502@N+9, 0x503@N+13, o_busy low at N+17.
REQ-031 SHALL cover clear plus refresh in IDLE: both pulsed at N -> 0x001@N+1, 0x080@N+10, then the slot writes at 4-cycle spacing.
REQ-032 SHALL cover collapse: three i_refresh pulses during a pass -> exactly one additional pass, with o_busy continuously high between the passes.
REQ-033 SHALL cover mid-sequence reset: i_rst asserted at cycle 20 -> o_comm=0x200 and o_init_done=0 immediately; after release the REQ-029 timeline repeats exactly.
REQ-034 SHALL cover requests during power-up: i_refresh at cycle 5 -> no extra pass; IDLE reached at cycle 47.
